fifo_wr_mem: RTL and testbench

- Write-domain half of the async FIFO: storage array, write pointer (binary and Gray), full / almost-full flags and overflow reporting, all clocked by w_clk.
- The read-domain Gray pointer enters through an internal multi-stage synchronizer.
- The read port is combinational on r_addr, driven by the read-domain pointer logic.
- Replaces the fixed 8-entry memory and generalises depth, width and synchronizer length.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_bus_sync.sv | 30 +++
 rtl/fifo_wr_mem.sv | 88 ++++++++
 tb/tb_fifo_wr_mem.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: Gray/binary pointer conversion and depth math.
// Conversions work on a fixed-width container; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

    localparam int PTR_MAX           = 16;
    localparam int DEFAULT_ADDR_SIZE = 3;
    localparam int DEPTH             = 1 << DEFAULT_ADDR_SIZE;

    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic int depth_of(input int addr_size);
        return 1 << addr_size;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper Gray bits decode to zero upper binary bits, so narrow pointers survive the round trip.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_bus_sync.sv
// Multi-flop synchronizer for a Gray-coded bus entering the w_clk domain.
// Only one bit changes per source update, so per-bit resolution is safe.
module fifo_bus_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             w_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_mem.sv
// Write-domain half of the async FIFO: storage, write pointers, full/almost-full/level flags.
// Flags are computed from a synchronized read pointer and are therefore pessimistic.
module fifo_wr_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_SIZE   = DEFAULT_ADDR_SIZE,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = DEPTH - 2
) (
    input  logic                  w_clk,
    input  logic                  reset,
    input  logic                  w_inc,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_SIZE-1:0]  r_addr,
    input  logic [ADDR_SIZE:0]    r_gptr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [ADDR_SIZE:0]    w_gptr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDR_SIZE:0]    w_level,
    output logic                  w_overflow
);

    localparam int PW        = ADDR_SIZE + 1;
    localparam int MEM_DEPTH = depth_of(ADDR_SIZE);
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [PW-1:0]         w_bin;
    logic [PW-1:0]         w_bin_next;
    logic [PW-1:0]         w_gnext;
    logic [PW-1:0]         rq_gptr;
    logic [PW-1:0]         rq_bin;
    logic [PW-1:0]         level_next;
    logic                  w_en;

    fifo_bus_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .w_clk (w_clk),
        .reset (reset),
        .d     (r_gptr),
        .q     (rq_gptr)
    );

    always_comb begin
        w_en       = w_inc & ~w_full;
        w_bin_next = w_bin + PW'(w_en);
        w_gnext    = PW'(bin2gray(ptr_t'(w_bin_next)));
        rq_bin     = PW'(gray2bin(ptr_t'(rq_gptr)));
        level_next = w_bin_next - rq_bin;
    end

    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            w_bin         <= '0;
            w_gptr        <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_level       <= '0;
            w_overflow    <= 1'b0;
        end else begin
            w_bin         <= w_bin_next;
            w_gptr        <= w_gnext;
            w_full        <= (w_gnext == (rq_gptr ^ FULL_MASK));
            w_almost_full <= (level_next >= PW'(AF_THRESH));
            w_level       <= level_next;
            w_overflow    <= w_inc & w_full;
        end
    end

    // Storage clears on reset so the combinational read port never shows stale data.
    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_en) begin
            mem[w_bin[ADDR_SIZE-1:0]] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: tb/tb_fifo_wr_mem.sv
// Bench for fifo_wr_mem: directed scenarios plus a randomized phase against an occupancy-count model.
// A second instance covers the wider/deeper parameter set.
module tb_fifo_wr_mem;

    localparam int D  = 8;
    localparam int S  = 2;
    localparam int AF = 6;

    logic        w_clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_inc = 1'b0;
    logic [7:0]  w_data = '0;
    logic [2:0]  r_addr = '0;
    logic [3:0]  r_gptr = '0;
    logic [7:0]  r_data;
    logic [3:0]  w_gptr;
    logic        w_full;
    logic        w_almost_full;
    logic [3:0]  w_level;
    logic        w_overflow;

    logic        b_inc = 1'b0;
    logic [15:0] b_data = '0;
    logic [3:0]  b_raddr = '0;
    logic [4:0]  b_rgptr = '0;
    logic [15:0] b_rdata;
    logic [4:0]  b_wgptr;
    logic        b_full;
    logic        b_af;
    logic [4:0]  b_level;
    logic        b_ovf;

    always #5 w_clk = ~w_clk;

    fifo_wr_mem dut (
        .w_clk (w_clk), .reset (reset), .w_inc (w_inc), .w_data (w_data),
        .r_addr (r_addr), .r_gptr (r_gptr), .r_data (r_data), .w_gptr (w_gptr),
        .w_full (w_full), .w_almost_full (w_almost_full), .w_level (w_level),
        .w_overflow (w_overflow)
    );

    fifo_wr_mem #(
        .DATA_WIDTH (16), .ADDR_SIZE (4), .SYNC_STAGES (3), .AF_THRESH (12)
    ) dut_b (
        .w_clk (w_clk), .reset (reset), .w_inc (b_inc), .w_data (b_data),
        .r_addr (b_raddr), .r_gptr (b_rgptr), .r_data (b_rdata), .w_gptr (b_wgptr),
        .w_full (b_full), .w_almost_full (b_af), .w_level (b_level),
        .w_overflow (b_ovf)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: counts of accepted writes and of reads, plus the read count the write side can see.
    int         wcnt, rcnt, level_m;
    logic       full_m, af_m, ovf_m;
    logic [7:0] mem_m [D];
    int         seen_q [$];
    logic [15:0] b_mem [16];

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_r(input int n);
        rcnt   = n;
        r_gptr = 4'(gray(n % (2 * D)));
    endtask

    task automatic model_reset();
        wcnt = 0; rcnt = 0; level_m = 0;
        full_m = 1'b0; af_m = 1'b0; ovf_m = 1'b0;
        for (int i = 0; i < D; i++) mem_m[i] = '0;
        seen_q.delete();
        for (int i = 0; i < S; i++) seen_q.push_back(0);
    endtask

    // Advance the model by one edge, wait for the edge, then compare every registered output.
    task automatic cycle();
        int seen;
        seen = seen_q.pop_front();
        seen_q.push_back(rcnt);
        ovf_m = w_inc && full_m;
        if (w_inc && !full_m) begin
            mem_m[wcnt % D] = w_data;
            wcnt++;
        end
        level_m = wcnt - seen;
        full_m  = (level_m == D);
        af_m    = (level_m >= AF);
        @(posedge w_clk);
        #1;
        chk("w_gptr", w_gptr, gray(wcnt % (2 * D)));
        chk("w_level", w_level, level_m);
        chk("w_full", w_full, full_m);
        chk("w_almost_full", w_almost_full, af_m);
        chk("w_overflow", w_overflow, ovf_m);
    endtask

    task automatic do_reset();
        r_addr = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_gptr", w_gptr, 0);
        chk("rst_level", w_level, 0);
        chk("rst_full", w_full, 0);
        chk("rst_rdata", r_data, 0);
        w_inc = 1'b0; b_inc = 1'b0; b_rgptr = '0;
        set_r(0);
        model_reset();
        @(negedge w_clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] gseq [8];
        gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        model_reset();

        repeat (2) @(posedge w_clk);
        #1;
        chk("init_gptr", w_gptr, 0);
        chk("init_level", w_level, 0);
        chk("init_full", w_full, 0);
        chk("init_af", w_almost_full, 0);
        chk("init_ovf", w_overflow, 0);
        chk("init_rdata", r_data, 0);
        chk("init_b_full", b_full, 0);
        @(negedge w_clk);
        reset = 1'b1;

        // Fill: eight writes of 0x11..0x88.
        for (int k = 0; k < D; k++) begin
            w_inc  = 1'b1;
            w_data = 8'((k + 1) * 8'h11);
            cycle();
            chk("gptr_seq", w_gptr, gseq[k]);
        end
        w_inc = 1'b0;
        for (int a = 0; a < D; a++) begin
            r_addr = 3'(a);
            cycle();
            chk("fill_rdata", r_data, 8'((a + 1) * 8'h11));
        end

        // Rejected write while full.
        w_inc  = 1'b1;
        w_data = 8'h99;
        cycle();
        chk("ovf_pulse", w_overflow, 1);
        w_inc = 1'b0;
        cycle();
        chk("ovf_end", w_overflow, 0);
        r_addr = '0;
        #1;
        chk("mem0_kept", r_data, 8'h11);

        // One read becomes visible to the full flag three edges later.
        set_r(1);
        for (int e = 1; e <= 3; e++) begin
            cycle();
            chk("full_vs_edge", w_full, e < 3);
        end
        chk("level_after_read", w_level, 7);
        w_inc  = 1'b1;
        w_data = 8'hA5;
        cycle();
        w_inc = 1'b0;
        #1;
        chk("mem0_new", r_data, 8'hA5);

        // Wrap-around with the read pointer trailing the write pointer.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            w_inc  = 1'b1;
            w_data = 8'($urandom);
            cycle();
            chk("wrap_msb", w_gptr[3], (wcnt / D) % 2);
            chk("wrap_level_le2", w_level <= 2, 1);
            w_inc = 1'b0;
            set_r(wcnt);
            cycle();
        end

        // Asynchronous reset mid-stream after five writes.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            w_inc  = 1'b1;
            w_data = 8'(8'h31 + k);
            cycle();
        end
        w_inc = 1'b0;
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            w_inc  = ($urandom_range(0, 3) != 0);
            w_data = 8'($urandom);
            if (rcnt < wcnt && $urandom_range(0, 2) == 0) set_r(rcnt + 1);
            r_addr = 3'($urandom_range(0, D - 1));
            cycle();
            chk("rnd_rdata", r_data, mem_m[r_addr]);
        end
        w_inc = 1'b0;

        // Wider/deeper instance: 16 entries, three sync stages, threshold 12.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            b_inc       = 1'b1;
            b_data      = 16'($urandom);
            b_mem[k-1]  = b_data;
            @(posedge w_clk);
            #1;
            chk("b_full", b_full, k == 16);
            chk("b_af", b_af, k >= 12);
            chk("b_level", b_level, k);
            chk("b_gptr", b_wgptr, gray(k % 32));
            chk("b_ovf", b_ovf, 0);
        end
        b_inc   = 1'b0;
        b_raddr = 4'd5;
        #1;
        chk("b_rdata", b_rdata, b_mem[5]);
        b_rgptr = 5'(gray(1));
        for (int e = 1; e <= 4; e++) begin
            @(posedge w_clk);
            #1;
            chk("b_full_vs_edge", b_full, e < 4);
        end
        chk("b_level_after_read", b_level, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
